// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the memory access stage.
// Optional build macro used by the stage: MEM_MISALIGN_TRAP_EN.
package mem_access_unit_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] LB       = 4'd1;
  localparam logic [3:0] LH       = 4'd2;
  localparam logic [3:0] LW       = 4'd3;
  localparam logic [3:0] LBU      = 4'd4;
  localparam logic [3:0] LHU      = 4'd5;
  localparam logic [3:0] SB       = 4'd6;
  localparam logic [3:0] SH       = 4'd7;
  localparam logic [3:0] SW       = 4'd8;

  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG       = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } mem_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {SB, SH, SW};
  endfunction

  // Number of bus bytes moved by an op; non-memory codes report 1 but are never used.
  function automatic logic [2:0] op_len(input logic [3:0] op);
    case (op)
      LH, LHU, SH: return 3'd2;
      LW, SW:      return 3'd4;
      default:     return 3'd1;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    case (op)
      LH, LHU, SH: return addr_lo[0];
      LW, SW:      return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of the assembled load bytes according to the op code.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] value
);

  always_comb begin
    value = raw;
    case (op)
      LB:      value = {{24{raw[7]}}, raw[7:0]};
      LH:      value = {{16{raw[15]}}, raw[15:0]};
      LBU:     value = {24'h000000, raw[7:0]};
      LHU:     value = {16'h0000, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: passes ALU results through and runs loads/stores byte-serially over an 8-bit bus.
// Build macro MEM_MISALIGN_TRAP_EN adds a misalign output and skips misaligned halfword/word accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  me_w_enable,
  input  logic [REG_ADDR_W-1:0] me_w_addr,
  input  logic [31:0]           me_w_data,
  input  logic [3:0]            me_mem_op,
  input  logic [31:0]           me_store_data,
  output logic                  stall_req,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  misalign,
`endif
  output logic                  wb_w_enable,
  output logic [REG_ADDR_W-1:0] wb_w_addr,
  output logic [31:0]           wb_w_data
);

  mem_state_t  state;
  logic [1:0]  idx;
  logic [31:0] asm_data;
  logic        trap_q;
  logic        trap;
  logic        op_load;
  logic        op_mem;
  logic        last_byte;
  logic [2:0]  len;
  logic [31:0] ext_value;

  assign op_load   = is_load(me_mem_op);
  assign op_mem    = op_load | is_store(me_mem_op);
  assign len       = op_len(me_mem_op);
  assign last_byte = ({1'b0, idx} == (len - 3'd1));

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap     = op_misaligned(me_mem_op, me_w_data[1:0]);
  assign misalign = trap_q;
`else
  assign trap     = 1'b0;
`endif

  // Address and write byte come from the held EX/ME inputs plus the byte index, so they stay put while waiting on ack.
  assign mem_addr  = ADDR_W'(me_w_data) + ADDR_W'(idx);
  assign mem_wdata = me_store_data[{idx, 3'b000} +: 8];
  assign stall_req = ((state == ST_IDLE) && op_mem) || (state == ST_ACCESS);

  mem_access_unit_load_extend u_load_extend (
    .op    (me_mem_op),
    .raw   (asm_data),
    .value (ext_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= 2'd0;
      asm_data <= ZERO_WORD;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_mem) begin
            idx      <= 2'd0;
            asm_data <= ZERO_WORD;
            if (trap) begin
              state  <= ST_DONE;
              trap_q <= 1'b1;
            end else begin
              state   <= ST_ACCESS;
              mem_req <= 1'b1;
              mem_we  <= is_store(me_mem_op);
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (op_load) asm_data[{idx, 3'b000} +: 8] <= mem_rdata;
            if (last_byte) begin
              state   <= ST_DONE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          idx    <= 2'd0;
          trap_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writeback is only enabled for plain passthrough and for a completed, untrapped load.
  always_comb begin
    wb_w_enable = WRITE_DISABLE;
    wb_w_addr   = me_w_addr;
    wb_w_data   = me_w_data;
    case (state)
      ST_IDLE: if (!op_mem) wb_w_enable = me_w_enable;
      ST_DONE: begin
        if (op_load && !trap_q) begin
          wb_w_enable = me_w_enable;
          wb_w_data   = ext_value;
        end
      end
      default: wb_w_enable = WRITE_DISABLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a transaction-level model and bus responder.
// Honours MEM_MISALIGN_TRAP_EN when defined for the build.
module tb_mem_access_unit;

  localparam logic [3:0] T_NONE = 4'd0, T_LB = 4'd1, T_LH = 4'd2, T_LW = 4'd3, T_LBU = 4'd4;
  localparam logic [3:0] T_LHU = 4'd5, T_SB = 4'd6, T_SH = 4'd7, T_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_w_enable;
  logic [4:0]  me_w_addr;
  logic [31:0] me_w_data;
  logic [3:0]  me_mem_op;
  logic [31:0] me_store_data;
  logic        stall_req, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_w_enable;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  bus_mem [logic [31:0]];
  int          cfg_wait, wait_left, acked, stall_cnt, exp_stall, cmp_idx;
  logic        chk_on, in_mem_op, done_seen, exp_trap, exp_en;
  logic [3:0]  cur_op;
  logic [4:0]  cur_rd;
  logic [31:0] cur_addr, cur_sdata, exp_data, last_data;
  logic        last_en;
  int          last_stall;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .me_w_enable   (me_w_enable),
    .me_w_addr     (me_w_addr),
    .me_w_data     (me_w_data),
    .me_mem_op     (me_mem_op),
    .me_store_data (me_store_data),
    .stall_req     (stall_req),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign      (misalign),
`endif
    .wb_w_enable   (wb_w_enable),
    .wb_w_addr     (wb_w_addr),
    .wb_w_data     (wb_w_data)
  );

  function automatic int m_len(input logic [3:0] op);
    if (op == T_LH || op == T_LHU || op == T_SH) return 2;
    if (op == T_LW || op == T_SW) return 4;
    return 1;
  endfunction

  function automatic logic m_load(input logic [3:0] op);
    return op >= T_LB && op <= T_LHU;
  endfunction

  function automatic logic m_store(input logic [3:0] op);
    return op >= T_SB && op <= T_SW;
  endfunction

  function automatic logic m_trap(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (m_load(op) || m_store(op)) && (a % m_len(op) != 0);
`else
    return 1'b0 && (op == a[3:0]);
`endif
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Bus slave: acks each byte after cfg_wait extra cycles; junk ack while idle.
  always begin
    @(posedge clk);
    #2;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_left > 0) wait_left--;
      else begin
        mem_ack = 1'b1;
        acked++;
        if (mem_we) bus_mem[mem_addr] = mem_wdata;
        else mem_rdata = bus_rd(mem_addr);
        wait_left = cfg_wait;
      end
    end else begin
      mem_ack = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (!in_mem_op) begin
        checkOutput("pass_stall", 32'(stall_req), 32'd0);
        checkOutput("pass_req", 32'(mem_req), 32'd0);
        checkOutput("pass_en", 32'(wb_w_enable), 32'(me_w_enable));
        checkOutput("pass_addr", 32'(wb_w_addr), 32'(me_w_addr));
        checkOutput("pass_data", wb_w_data, me_w_data);
      end else if (stall_req) begin
        stall_cnt++;
        checkOutput("busy_wb_en", 32'(wb_w_enable), 32'd0);
        checkOutput("busy_req", 32'(mem_req), 32'(stall_cnt > 1));
        if (mem_req) begin
          cmp_idx = acked - int'(mem_ack);
          checkOutput("bus_addr", mem_addr, cur_addr + 32'(cmp_idx));
          checkOutput("bus_we", 32'(mem_we), 32'(m_store(cur_op)));
          if (m_store(cur_op))
            checkOutput("bus_wdata", 32'(mem_wdata), 32'(8'(cur_sdata >> (8 * cmp_idx))));
        end
      end else begin
        checkOutput("done_cycles", 32'(stall_cnt), 32'(exp_stall));
        checkOutput("done_req", 32'(mem_req), 32'd0);
        checkOutput("done_wb_en", 32'(wb_w_enable), 32'(exp_en));
        checkOutput("done_wb_addr", 32'(wb_w_addr), 32'(cur_rd));
        if (m_load(cur_op) && !exp_trap) checkOutput("done_wb_data", wb_w_data, exp_data);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("done_misalign", 32'(misalign), 32'(exp_trap));
`endif
        last_data  = wb_w_data;
        last_en    = wb_w_enable;
        last_stall = stall_cnt;
        in_mem_op  = 1'b0;
        done_seen  = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic en, input logic [4:0] rd,
                               input logic [31:0] addr, input logic [31:0] sd, input int wt);
    logic [31:0] raw;
    int len;
    @(posedge clk);
    #1;
    me_mem_op = op; me_w_enable = en; me_w_addr = rd; me_w_data = addr; me_store_data = sd;
    cur_op = op; cur_rd = rd; cur_addr = addr; cur_sdata = sd;
    cfg_wait = wt; wait_left = wt; acked = 0; stall_cnt = 0; done_seen = 1'b0;
    len = m_len(op);
    exp_trap = m_trap(op, addr);
    raw = 32'd0;
    for (int i = 0; i < len; i++) raw = raw + (32'(bus_rd(addr + 32'(i))) << (8 * i));
    exp_data = raw;
    if (op == T_LB && raw >= 32'd128) exp_data = raw - 32'd256;
    if (op == T_LH && raw >= 32'd32768) exp_data = raw - 32'd65536;
    exp_en = (m_load(op) && !exp_trap) ? en : 1'b0;
    exp_stall = exp_trap ? 1 : 1 + len * (1 + wt);
    if (m_load(op) || m_store(op)) begin
      in_mem_op = 1'b1;
      for (int c = 0; c < 300 && !done_seen; c++) begin
        @(negedge clk);
        #1;
      end
      if (!done_seen) begin
        checkOutput("op_timeout", 32'd0, 32'd1);
        in_mem_op = 1'b0;
      end
    end else begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; chk_on = 1'b0; in_mem_op = 1'b0; done_seen = 1'b0;
    me_w_enable = 1'b0; me_w_addr = 5'd0; me_w_data = 32'd0; me_mem_op = T_NONE; me_store_data = 32'd0;
    mem_ack = 1'b0; mem_rdata = 8'd0; cfg_wait = 0; wait_left = 0; acked = 0;
    bus_mem[32'h100] = 8'h78; bus_mem[32'h101] = 8'h56; bus_mem[32'h102] = 8'h34; bus_mem[32'h103] = 8'h12;
    bus_mem[32'h203] = 8'h80; bus_mem[32'h300] = 8'h80; bus_mem[32'h301] = 8'hFF;
    bus_mem[32'h10] = 8'h11; bus_mem[32'h11] = 8'h22; bus_mem[32'h12] = 8'h33; bus_mem[32'h13] = 8'h44;
    bus_mem[32'h40] = 8'h00; bus_mem[32'h41] = 8'h00; bus_mem[32'h42] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", 32'(stall_req), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;

    applyStimulus(T_NONE, 1'b1, 5'd5, 32'h1234, 32'd0, 0);
    checkOutput("alu_en", 32'(wb_w_enable), 32'd1);
    checkOutput("alu_addr", 32'(wb_w_addr), 32'd5);
    checkOutput("alu_data", wb_w_data, 32'h1234);

    applyStimulus(T_LW, 1'b1, 5'd7, 32'h100, 32'd0, 0);
    checkOutput("lw_lit", last_data, 32'h12345678);
    checkOutput("lw_stall", 32'(last_stall), 32'd5);
    applyStimulus(T_LB, 1'b1, 5'd3, 32'h203, 32'd0, 1);
    checkOutput("lb_lit", last_data, 32'hFFFFFF80);
    applyStimulus(T_LBU, 1'b1, 5'd3, 32'h203, 32'd0, 0);
    checkOutput("lbu_lit", last_data, 32'h00000080);
    applyStimulus(T_LH, 1'b1, 5'd4, 32'h300, 32'd0, 0);
    checkOutput("lh_lit", last_data, 32'hFFFFFF80);

    applyStimulus(T_SH, 1'b1, 5'd9, 32'h40, 32'hDEADBEEF, 2);
    checkOutput("sh_b0", 32'(bus_mem[32'h40]), 32'hEF);
    checkOutput("sh_b1", 32'(bus_mem[32'h41]), 32'hBE);
    checkOutput("sh_b2", 32'(bus_mem[32'h42]), 32'h00);
    checkOutput("sh_en", 32'(last_en), 32'd0);
    checkOutput("sh_stall", 32'(last_stall), 32'd7);

    // Abort an LW after its second byte with a reset, then rerun a clean LW.
    chk_on = 1'b0;
    @(posedge clk);
    #1;
    me_mem_op = T_LW; me_w_enable = 1'b1; me_w_addr = 5'd2; me_w_data = 32'h300;
    cfg_wait = 0; wait_left = 0; acked = 0;
    for (int c = 0; c < 20 && acked < 2; c++) @(negedge clk);
    checkOutput("rst_mid_reach", 32'(acked >= 2), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    me_mem_op = T_NONE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mid_stall", 32'(stall_req), 32'd0);
    checkOutput("rst_mid_en", 32'(wb_w_enable), 32'd1);
    in_mem_op = 1'b0;
    chk_on = 1'b1;
    applyStimulus(T_LW, 1'b1, 5'd6, 32'h10, 32'd0, 0);
    checkOutput("lw_after_rst", last_data, 32'h44332211);

    applyStimulus(T_LW, 1'b1, 5'd8, 32'h102, 32'd0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    checkOutput("mis_stall", 32'(last_stall), 32'd1);
    checkOutput("mis_en", 32'(last_en), 32'd0);
`else
    checkOutput("mis_stall", 32'(last_stall), 32'd5);
    checkOutput("mis_data", last_data, 32'h5F5E1234);
`endif

    applyStimulus(4'd12, 1'b1, 5'd11, 32'hCAFE0001, 32'd0, 0);
    checkOutput("illegal_stall", 32'(stall_req), 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                      : 32'($urandom_range(0, 4095));
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom), 5'($urandom), a, $urandom,
                    int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage that consumes the EX/ME pipeline register outputs (write enable, destination register, data) and produces the ME/WB inputs.
- Non-memory ops pass through combinationally with zero added latency.
- Loads and stores run byte-serially over an 8-bit req/ack memory bus. The pipeline is held with stall_req until the access completes.

Parameters:
- ADDR_W, 32, memory address width
- REG_ADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- me_w_enable  in  1  write enable from EX/ME register
- me_w_addr  in  REG_ADDR_W  destination register
- me_w_data  in  32  ALU result; effective address for memory ops
- me_mem_op  in  4  memory op code (package encoding)
- me_store_data  in  32  rs2 value for stores
- stall_req  out  1  hold upstream pipeline registers
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte
- mem_ack  in  1  transfer complete
- wb_w_enable  out  1  to ME/WB register
- wb_w_addr  out  REG_ADDR_W  to ME/WB register
- wb_w_data  out  32  to ME/WB register

Behaviour:
- Clock and reset: clk, rst; reset is synchronous, active-high.
- Reset state: IDLE, byte index 0, assembly register 0, mem_req 0, mem_we 0, stall_req 0.
- After reset, wb_* track the inputs as in the IDLE non-mem case.
- Upstream holds all me_* inputs stable while stall_req=1.
- Byte length: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Little-endian: byte i goes to/from bits [8i+7:8i].
- IDLE, op=MEM_NONE:
  - wb_w_enable=me_w_enable, wb_w_addr=me_w_addr, wb_w_data=me_w_data.
  - stall_req=0, mem_req=0.
- IDLE, load/store op:
  - stall_req=1, wb_w_enable=0.
  - Next state ACCESS with index 0; assembly register cleared.
- ACCESS:
  - mem_req=1, mem_addr=me_w_data+index (wraps modulo 2^ADDR_W).
  - mem_we=1 for stores; mem_wdata=store byte[index].
  - stall_req=1.
  - On mem_ack: loads capture mem_rdata into byte[index].
  - If index==len-1 go to DONE; else index+1 and stay in ACCESS.
  - Ack in the same cycle as req is allowed (single-cycle bytes).
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and ack=0.
- mem_ack while mem_req=0 is ignored.
- DONE, one cycle:
  - stall_req=0, mem_req=0.
  - Loads: wb_w_enable=me_w_enable, wb_w_data = assembly value sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - Stores: wb_w_enable=0.
  - wb_w_addr=me_w_addr. Next state IDLE.
  - Upstream advances at the DONE edge.
- Back-to-back memory ops: at least 1 DONE cycle, then IDLE evaluates the next op.
- Illegal op codes (9-15) are treated as MEM_NONE.
- Reset mid-operation: IDLE at the next edge; the partial load is discarded; a store may be partially written (no rollback).
- Latency: a memory op takes len bus transfers plus 2 cycles (IDLE detect + DONE) with zero-wait ack.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword ops with addr[0]≠0, or word ops with addr[1:0]≠0, go IDLE→DONE directly with no bus cycle.
  - Extra output misalign (1 bit) pulses high in that DONE cycle; wb_w_enable=0.
  - misalign resets to 0.
- Undefined: no port; misaligned accesses are performed byte-serially like aligned ones.

Decomposition:
- Shared package/header: op encodings MEM_NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; state encodings; existing write-disable/zero-word/NOP-register constants.
- One natural sub-module, load_extend: combinational sign/zero extension of the assembled value by op.

Test Plan:
- ALU passthrough: op=NONE, en=1, addr=5, data=0x1234 → same-cycle wb_*=(1,5,0x1234); stall_req=0; mem_req never 1.
- LW at 0x100, bytes 78,56,34,12, immediate ack → requests to 0x100..0x103 on 4 consecutive cycles; DONE wb_w_data=0x12345678; stall_req high 5 cycles total.
- LB at 0x203 reading 0x80 → wb_w_data=0xFFFFFF80; LBU → 0x00000080; LH reading 0x80,0xFF → 0xFFFFFF80 sign-extended from 0xFF80.
- SH store_data=0xDEADBEEF at 0x40, ack delayed 2 cycles per byte → writes 0xEF@0x40 then 0xBE@0x41; addr/wdata stable while waiting; wb_w_enable=0 in DONE.
- Reset after the 2nd byte of an LW → next cycle IDLE, mem_req=0; a following LW at 0x10 starts at 0x10 with the correct full result.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 → no mem_req, misalign=1 for one cycle, wb_w_enable=0; without the macro → 4 byte reads at 0x102..0x105.
